// File: rtl/vga_text_engine.sv
// rtl/vga_text_engine.sv - VGA character-mode display controller with blink and cursor
//
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   en                display enable (RGB forced to 0 when low, syncs keep running)
//   text_addr         {row, col} of the cell being fetched (0 outside active video)
//   text_data         {blink, fg, bg, ascii} returned MEM_LAT clocks after text_addr
//   font_addr         {ascii, glyph line}
//   font_data         glyph row, MSB = leftmost pixel, FONT_LAT clocks after font_addr
//   cursor_en/col/row hardware cursor control, sampled with the fetch address
//   r, g, b, de       registered colour outputs and active-video flag
//   hs, vs            registered sync outputs, polarity set by SYNC_POL
//   frame_start       one-clock pulse on the first active pixel of each frame
module vga_text_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit SYNC_POL     = 1'b0,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int CW           = 4,
    parameter int MEM_LAT      = 1,
    parameter int FONT_LAT     = 1,
    parameter int BLINK_FRAMES = 32,
    localparam int COLS_W      = $clog2(H_ACTIVE / CHAR_W),
    localparam int ROWS_W      = $clog2(V_ACTIVE / CHAR_H),
    localparam int LINE_W      = $clog2(CHAR_H)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    output logic [COLS_W+ROWS_W-1:0]   text_addr,
    input  logic [6*CW+8:0]            text_data,
    output logic [8+LINE_W-1:0]        font_addr,
    input  logic [CHAR_W-1:0]          font_data,
    input  logic                       cursor_en,
    input  logic [COLS_W-1:0]          cursor_col,
    input  logic [ROWS_W-1:0]          cursor_row,
    output logic [CW-1:0]              r,
    output logic [CW-1:0]              g,
    output logic [CW-1:0]              b,
    output logic                       hs,
    output logic                       vs,
    output logic                       de,
    output logic                       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W     = $clog2(CHAR_W);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int PIPE    = MEM_LAT + FONT_LAT;
    localparam int CTL_W   = X_W + 5;
    localparam int ATTR_W  = 6 * CW + 1;
    localparam int BF_W    = $clog2(BLINK_FRAMES + 1);

    localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT_LAST = HCW'(H_ACTIVE - 1);
    localparam logic [VCW-1:0] V_ACT_LAST = VCW'(V_ACTIVE - 1);
    localparam logic [HCW-1:0] HS_FIRST   = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_LAST    = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VCW-1:0] VS_FIRST   = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_LAST    = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [BF_W-1:0] BF_LAST   = BF_W'(BLINK_FRAMES - 1);
    // Control word layout: {pixel x, cursor hit, de, hs, vs, frame_start}
    localparam logic [CTL_W-1:0] CTL_RST  = {{X_W{1'b0}}, 1'b0, 1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0};

    logic [HCW-1:0]    r_h;
    logic [VCW-1:0]    r_v;
    logic [BF_W-1:0]   r_frame_cnt;
    logic              r_blink_phase;
    logic [CTL_W-1:0]  r_ctl  [PIPE];
    logic [LINE_W-1:0] r_line [MEM_LAT];
    logic [ATTR_W-1:0] r_attr [FONT_LAT];
    logic [3*CW-1:0]   r_rgb;
    logic              r_de, r_hs, r_vs, r_fs;

    // Beam counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Stage 0: decode counters into fetch address and control word
    logic              w_de0, w_hs0, w_vs0, w_fs0, w_cur0, w_vs_start;
    logic [COLS_W-1:0] w_col0;
    logic [ROWS_W-1:0] w_row0;
    logic [LINE_W-1:0] w_line0;
    logic [X_W-1:0]    w_x0;
    logic [CTL_W-1:0]  w_ctl0;

    assign w_de0      = (r_h <= H_ACT_LAST) && (r_v <= V_ACT_LAST);
    assign w_hs0      = ((r_h >= HS_FIRST) && (r_h <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    assign w_vs0      = ((r_v >= VS_FIRST) && (r_v <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    assign w_fs0      = (r_h == '0) && (r_v == '0);
    assign w_vs_start = (r_h == '0) && (r_v == VS_FIRST);
    assign w_col0     = COLS_W'(r_h >> X_W);
    assign w_row0     = ROWS_W'(r_v >> LINE_W);
    assign w_line0    = r_v[LINE_W-1:0];
    assign w_x0       = r_h[X_W-1:0];
    // Cursor occupies the bottom two glyph lines and is hidden in the blink-off phase
    assign w_cur0     = cursor_en && (w_row0 == cursor_row) && (w_col0 == cursor_col) &&
                        (w_line0 >= LINE_W'(CHAR_H - 2)) && !r_blink_phase;
    assign w_ctl0     = {w_x0, w_cur0, w_de0, w_hs0, w_vs0, w_fs0};
    assign text_addr  = w_de0 ? {w_row0, w_col0} : '0;
    assign font_addr  = {text_data[7:0], r_line[MEM_LAT-1]};

    // Blink timebase: phase flips every BLINK_FRAMES vsync starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_vs_start) begin
            if (r_frame_cnt == BF_LAST) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Delay lines: control spans both memory latencies, line index covers the
    // text RAM only, attributes wait for the font ROM only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++)     r_ctl[i]  <= CTL_RST;
            for (int i = 0; i < MEM_LAT; i++)  r_line[i] <= '0;
            for (int i = 0; i < FONT_LAT; i++) r_attr[i] <= '0;
        end else begin
            r_ctl[0]  <= w_ctl0;
            r_line[0] <= w_line0;
            r_attr[0] <= text_data[6*CW+8:8];
            for (int i = 1; i < PIPE; i++)     r_ctl[i]  <= r_ctl[i-1];
            for (int i = 1; i < MEM_LAT; i++)  r_line[i] <= r_line[i-1];
            for (int i = 1; i < FONT_LAT; i++) r_attr[i] <= r_attr[i-1];
        end
    end

    // Final stage: pixel select, blink/cursor override, colour mux
    logic [X_W-1:0]   w_x;
    logic [X_W-1:0]   w_bit_idx;
    logic             w_cur, w_de, w_hs, w_vs, w_fs, w_blink, w_pix;
    logic [3*CW-1:0]  w_fg, w_bg;
    logic [ATTR_W-1:0] w_attr;

    assign {w_x, w_cur, w_de, w_hs, w_vs, w_fs} = r_ctl[PIPE-1];
    assign w_attr    = r_attr[FONT_LAT-1];
    assign w_blink   = w_attr[6*CW];
    assign w_fg      = w_attr[6*CW-1:3*CW];
    assign w_bg      = w_attr[3*CW-1:0];
    assign w_bit_idx = X_W'(CHAR_W - 1) - w_x;
    assign w_pix     = w_cur || (font_data[w_bit_idx] && !(w_blink && r_blink_phase));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
            r_de  <= 1'b0;
            r_hs  <= ~SYNC_POL;
            r_vs  <= ~SYNC_POL;
            r_fs  <= 1'b0;
        end else begin
            r_rgb <= (w_de && en) ? (w_pix ? w_fg : w_bg) : '0;
            r_de  <= w_de;
            r_hs  <= w_hs;
            r_vs  <= w_vs;
            r_fs  <= w_fs;
        end
    end

    assign r           = r_rgb[3*CW-1:2*CW];
    assign g           = r_rgb[2*CW-1:CW];
    assign b           = r_rgb[CW-1:0];
    assign de          = r_de;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_text_engine.sv
// tb/tb_vga_text_engine.sv - randomized self-checking bench for vga_text_engine
module tb_vga_text_engine;
    localparam int HA = 32, HF = 4, HSY = 6, HB = 6;
    localparam int VA = 32, VF = 2, VSY = 2, VB = 2;
    localparam int CWD = 8, CHH = 8, CW = 4, ML = 2, FL = 2, BF = 2;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FT = HT * VT;
    localparam int L  = ML + FL + 1;
    localparam int COLS_W = $clog2(HA / CWD);
    localparam int ROWS_W = $clog2(VA / CHH);
    localparam int LINE_W = $clog2(CHH);
    localparam int TAW = COLS_W + ROWS_W;
    localparam int FAW = 8 + LINE_W;
    localparam int TW  = 6 * CW + 9;
    localparam int NF  = 6;

    logic clk = 1'b0;
    logic rst, en, cursor_en;
    logic [TAW-1:0]    text_addr;
    logic [TW-1:0]     text_data;
    logic [FAW-1:0]    font_addr;
    logic [CWD-1:0]    font_data;
    logic [COLS_W-1:0] cursor_col;
    logic [ROWS_W-1:0] cursor_row;
    logic [CW-1:0]     r, g, b;
    logic              hs, vs, de, frame_start;

    vga_text_engine #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .SYNC_POL(1'b0), .CHAR_W(CWD), .CHAR_H(CHH), .CW(CW),
        .MEM_LAT(ML), .FONT_LAT(FL), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Memory models with fixed read latency
    logic [TW-1:0]  tmem [1 << TAW];
    logic [7:0]     fmem [1 << FAW];
    logic [TAW-1:0] tq [ML];
    logic [FAW-1:0] fq [FL];

    always @(posedge clk) begin
        tq[0] <= text_addr;
        fq[0] <= font_addr;
        for (int i = 1; i < ML; i++) tq[i] <= tq[i-1];
        for (int i = 1; i < FL; i++) fq[i] <= fq[i-1];
    end
    assign text_data = tmem[tq[ML-1]];
    assign font_data = fmem[fq[FL-1]];

    // Per-frame configuration
    logic        en_cfg [16];
    logic        cen_cfg [16];
    int          ccol_cfg [16];
    int          crow_cfg [16];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic apply_cfg(input int f);
        en         = en_cfg[f];
        cursor_en  = cen_cfg[f];
        cursor_col = COLS_W'(ccol_cfg[f]);
        cursor_row = ROWS_W'(crow_cfg[f]);
    endtask

    // Expected outputs for beam position p (clocks since reset release)
    function automatic void model(input int p, output logic [3*CW-1:0] rgb_e,
                                  output logic de_e, output logic hs_e,
                                  output logic vs_e, output logic fs_e);
        int h, v, f, col, row, line, x, phase;
        logic [TW-1:0] a;
        logic [7:0]    fr;
        logic          bitv;
        h = p % HT;
        v = (p / HT) % VT;
        f = p / FT;
        de_e  = (h < HA) && (v < VA);
        hs_e  = !((h >= HA + HF) && (h < HA + HF + HSY));
        vs_e  = !((v >= VA + VF) && (v < VA + VF + VSY));
        fs_e  = (h == 0) && (v == 0);
        rgb_e = '0;
        if (de_e && en_cfg[f]) begin
            col   = h / CWD;
            row   = v / CHH;
            line  = v % CHH;
            x     = h % CWD;
            phase = (f / BF) % 2;
            a     = tmem[row * (1 << COLS_W) + col];
            fr    = fmem[int'(a[7:0]) * CHH + line];
            bitv  = fr[CWD - 1 - x];
            if (a[TW-1] && phase == 1) bitv = 1'b0;
            if (cen_cfg[f] && row == crow_cfg[f] && col == ccol_cfg[f] &&
                line >= CHH - 2 && phase == 0) bitv = 1'b1;
            rgb_e = bitv ? a[TW-2 -: 3*CW] : a[3*CW+7 -: 3*CW];
        end
    endfunction

    task automatic run(input int n);
        logic [3*CW-1:0] rgb_e;
        logic de_e, hs_e, vs_e, fs_e;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            cyc = k;
            if (k < L) begin
                rgb_e = '0; de_e = 1'b0; hs_e = 1'b1; vs_e = 1'b1; fs_e = 1'b0;
            end else begin
                model(k - L, rgb_e, de_e, hs_e, vs_e, fs_e);
            end
            check("rgb", 32'({r, g, b}), 32'(rgb_e));
            check("de", 32'(de), 32'(de_e));
            check("hs", 32'(hs), 32'(hs_e));
            check("vs", 32'(vs), 32'(vs_e));
            check("frame_start", 32'(frame_start), 32'(fs_e));
            // Reconfigure while the fetch stage is in vertical blanking
            if (k % FT == VA * HT) apply_cfg(k / FT + 1);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << TAW); i++) tmem[i] = TW'({$urandom(), $urandom()});
        for (int i = 0; i < (1 << FAW); i++) fmem[i] = 8'($urandom());
        tmem[0] = {1'b0, 12'hFFF, 12'h008, 8'h41};
        fmem[{8'h41, 3'd0}] = 8'h81;
        tmem[1] = {1'b1, 12'hF0F, 12'h0A0, 8'h42};
        fmem[{8'h42, 3'd3}] = 8'hFF;
        for (int f = 0; f < 16; f++) begin
            en_cfg[f]   = 1'b1;
            cen_cfg[f]  = 1'($urandom_range(0, 1));
            ccol_cfg[f] = int'($urandom_range(0, (1 << COLS_W) - 1));
            crow_cfg[f] = int'($urandom_range(0, (1 << ROWS_W) - 1));
        end
        cen_cfg[0] = 1'b1; ccol_cfg[0] = 1; crow_cfg[0] = 2;
        cen_cfg[1] = 1'b1; ccol_cfg[1] = 1; crow_cfg[1] = 2;
        cen_cfg[4] = 1'b1; ccol_cfg[4] = 0; crow_cfg[4] = 0;
        en_cfg[3]  = 1'b0;

        rst = 1'b1;
        apply_cfg(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Run into the middle of hsync and vsync, then reset asynchronously
        run(L + (VA + VF) * HT + HA + HF + 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_rgb", 32'({r, g, b}), 32'h0);
        check("rst_async_de", 32'(de), 32'h0);
        check("rst_async_hs", 32'(hs), 32'h1);
        check("rst_async_vs", 32'(vs), 32'h1);
        check("rst_async_fs", 32'(frame_start), 32'h0);
        check("rst_async_addr", 32'(text_addr), 32'h0);
        apply_cfg(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold_de", 32'(de), 32'h0);
        check("rst_hold_hs", 32'(hs), 32'h1);
        rst = 1'b0;

        run(NF * FT + L);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
